ifetch_unit: RTL and testbench

Instruction fetch front end. Generates the PC stream and fetches 32-bit words from the memory controller with a single outstanding request. Buffers fetched {pc, instr} pairs in a small queue and presents them to the decoder over a valid/ready handshake. A branch redirect flushes the queue and restarts fetch at the new PC.

---
 rtl/ifetch_unit_pkg.sv | 22 ++
 rtl/ifetch_queue.sv | 70 +++++++
 rtl/ifetch_unit.sv | 157 +++++++++++++++
 tb/tb_ifetch_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_unit_pkg.sv
// rtl/ifetch_unit_pkg.sv - shared constants, entry type and JAL helper for the fetch unit
package ifetch_unit_pkg;

    localparam int         INSTR_W    = 32;
    localparam logic [6:0] OPCODE_JAL = 7'b1101111;

    localparam logic [1:0] IF_IDLE    = 2'd0;
    localparam logic [1:0] IF_WAIT    = 2'd1;
    localparam logic [1:0] IF_DISCARD = 2'd2;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
        logic               pred;
    } fetch_entry_t;

    // Sign-extended byte offset of a JAL instruction.
    function automatic logic [31:0] jal_offset(input logic [INSTR_W-1:0] instr);
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - synchronous FIFO of fetched {pc, instr, pred} entries with flush
module ifetch_queue
    import ifetch_unit_pkg::*;
#(
    parameter int   DEPTH = 4,
    localparam int  AW    = $clog2(DEPTH)
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [AW:0]  count,
    output logic         empty,
    output logic         full
);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));

    // Next pointers, count and storage; flush wins over any push or pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // Register state; storage is cleared so the head reads zero out of reset.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch front end; optional JAL prediction via IFETCH_JAL_PREDICT_EN
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    output logic               mem_req,
    output logic [31:0]        mem_addr,
    input  logic               mem_valid,
    input  logic [INSTR_W-1:0] mem_data,
    input  logic               jump_en,
    input  logic [31:0]        jump_pc,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [31:0]        dec_pc,
    output logic [INSTR_W-1:0] dec_instr,
    output logic               dec_pred_jump
);

    localparam int AW = $clog2(QUEUE_DEPTH);

    logic [1:0]   state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         mem_req_q, mem_req_d;
    logic [31:0]  mem_addr_q, mem_addr_d;

    logic         q_push, q_pop, q_flush;
    fetch_entry_t q_din, q_head;
    logic [AW:0]  q_count, count_after;
    logic         q_empty, q_full;
    logic [31:0]  next_pc;
    logic         pred;
    logic         unused_jump_lsbs;

    assign unused_jump_lsbs = ^jump_pc[1:0];

    assign mem_req       = mem_req_q;
    assign mem_addr      = mem_addr_q;
    assign dec_valid     = !q_empty;
    assign dec_pc        = q_head.pc;
    assign dec_instr     = q_head.instr;
    assign dec_pred_jump = q_head.pred;

    // Queue control: everything frozen while rdy_in is low, redirect beats push and pop.
    assign q_flush     = rdy_in && jump_en;
    assign q_pop       = rdy_in && !jump_en && dec_valid && dec_ready;
    assign q_push      = rdy_in && !jump_en && (state_q == IF_WAIT) && mem_valid;
    assign q_din       = {fetch_pc_q, mem_data, pred};
    assign count_after = q_count + {{AW{1'b0}}, q_push} - {{AW{1'b0}}, q_pop};

    ifetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .push   (q_push),
        .pop    (q_pop),
        .flush  (q_flush),
        .din    (q_din),
        .head   (q_head),
        .count  (q_count),
        .empty  (q_empty),
        .full   (q_full)
    );

    // Sequential PC successor and prediction bit for the word returning now.
    always_comb begin
        pred    = 1'b0;
        next_pc = fetch_pc_q + 32'd4;
`ifdef IFETCH_JAL_PREDICT_EN
        if (mem_data[6:0] == OPCODE_JAL) begin
            pred    = 1'b1;
            next_pc = fetch_pc_q + jal_offset(mem_data);
        end
`endif
    end

    // Fetch state machine with a single outstanding request.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        if (rdy_in) begin
            if (jump_en) begin
                fetch_pc_d = {jump_pc[31:2], 2'b00};
                case (state_q)
                    IF_WAIT: begin
                        if (mem_valid) begin
                            mem_req_d = 1'b0;
                            state_d   = IF_IDLE;
                        end else begin
                            state_d   = IF_DISCARD;
                        end
                    end
                    // A stale response landing with the redirect is consumed here, else we would wait forever.
                    IF_DISCARD: begin
                        if (mem_valid) begin
                            mem_req_d = 1'b0;
                            state_d   = IF_IDLE;
                        end
                    end
                    default: state_d = IF_IDLE;
                endcase
            end else begin
                case (state_q)
                    IF_IDLE: begin
                        if (!q_full) begin
                            mem_req_d  = 1'b1;
                            mem_addr_d = fetch_pc_q;
                            state_d    = IF_WAIT;
                        end
                    end
                    IF_WAIT: begin
                        if (mem_valid) begin
                            fetch_pc_d = next_pc;
                            if (count_after != (AW+1)'(QUEUE_DEPTH)) begin
                                mem_addr_d = next_pc;
                            end else begin
                                mem_req_d  = 1'b0;
                                state_d    = IF_IDLE;
                            end
                        end
                    end
                    IF_DISCARD: begin
                        if (mem_valid) begin
                            mem_req_d = 1'b0;
                            state_d   = IF_IDLE;
                        end
                    end
                    default: begin
                        mem_req_d = 1'b0;
                        state_d   = IF_IDLE;
                    end
                endcase
            end
        end
    end

    // State, PC and request registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= IF_IDLE;
            fetch_pc_q <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - scoreboard bench for ifetch_unit with a latency-controlled memory model
module tb_ifetch_unit;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_data = 32'h0;
    logic        jump_en = 1'b0;
    logic [31:0] jump_pc = 32'h0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;
    logic        dec_pred_jump;

    ifetch_unit #(.RESET_PC(32'h0), .QUEUE_DEPTH(4)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_valid     (mem_valid),
        .mem_data      (mem_data),
        .jump_en       (jump_en),
        .jump_pc       (jump_pc),
        .dec_valid     (dec_valid),
        .dec_ready     (dec_ready),
        .dec_pc        (dec_pc),
        .dec_instr     (dec_instr),
        .dec_pred_jump (dec_pred_jump)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred;
    } exp_t;

    exp_t        sb [$];
    exp_t        mon_e;
    logic [31:0] req_log [$];
    int          vectors = 0;
    int          miscompares = 0;
    int          pops_seen = 0;
    int          resp_cnt = 0;

    int          mem_lat = 1;
    bit          jal_mode = 1'b0;
    bit          pending = 1'b0;
    int          lat_cnt = 0;
    logic [31:0] pend_addr = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (jal_mode && a == 32'h20) return 32'h0100_006F;
        return {a[23:0], 8'h13};
    endfunction

    // Memory controller model: one request at a time, response after mem_lat idle cycles.
    initial begin
        forever begin
            @(posedge clk_in);
            #2;
            if (!rst_in) begin
                pending   = 1'b0;
                mem_valid = 1'b0;
            end else begin
                mem_valid = 1'b0;
                if (rdy_in) begin
                    if (pending) begin
                        if (lat_cnt == 0) begin
                            mem_valid = 1'b1;
                            mem_data  = mem_word(pend_addr);
                            pending   = 1'b0;
                            resp_cnt++;
                        end else begin
                            lat_cnt--;
                        end
                    end else if (mem_req) begin
                        pending   = 1'b1;
                        pend_addr = mem_addr;
                        lat_cnt   = mem_lat;
                        req_log.push_back(mem_addr);
                    end
                end
            end
        end
    end

    // Monitor: every accepted head is compared against the scoreboard front.
    always @(negedge clk_in) begin
        if (rst_in && rdy_in && dec_valid && dec_ready && !jump_en) begin
            vectors++;
            pops_seen++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL pop_unexpected: got pc=%h instr=%h pred=%b, scoreboard empty",
                         dec_pc, dec_instr, dec_pred_jump);
            end else begin
                mon_e = sb.pop_front();
                if (dec_pc !== mon_e.pc || dec_instr !== mon_e.instr || dec_pred_jump !== mon_e.pred) begin
                    miscompares++;
                    $display("FAIL pop_entry: got pc=%h instr=%h pred=%b, want pc=%h instr=%h pred=%b",
                             dec_pc, dec_instr, dec_pred_jump, mon_e.pc, mon_e.instr, mon_e.pred);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic exp_push(input logic [31:0] pc, input logic [31:0] instr, input logic pred);
        exp_t e;
        e.pc = pc;
        e.instr = instr;
        e.pred = pred;
        sb.push_back(e);
    endtask

    task automatic wait_pops(input int n, input string name);
        int budget = 300;
        while (pops_seen < n && budget > 0) begin
            tick();
            budget--;
        end
        if (pops_seen < n) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: got %0d pops, want %0d", name, pops_seen, n);
        end
    endtask

    task automatic enter_reset();
        tick();
        rst_in    = 1'b0;
        rdy_in    = 1'b1;
        jump_en   = 1'b0;
        dec_ready = 1'b0;
        tick();
        tick();
        sb.delete();
        req_log.delete();
        pops_seen = 0;
        resp_cnt  = 0;
    endtask

    initial begin
        int budget;
        int drops;
        int pops_before;
        bit seen_req;

        // Test 1: reset values, then streaming fetch with decoder always ready.
        enter_reset();
        check("rst_mem_req", {31'h0, mem_req}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_dec_valid", {31'h0, dec_valid}, 32'h0);
        check("rst_dec_pc", dec_pc, 32'h0);
        check("rst_dec_instr", dec_instr, 32'h0);
        check("rst_dec_pred", {31'h0, dec_pred_jump}, 32'h0);
        mem_lat = 1;
        exp_push(32'h0, 32'h0000_0013, 1'b0);
        exp_push(32'h4, 32'h0000_0413, 1'b0);
        exp_push(32'h8, 32'h0000_0813, 1'b0);
        rst_in    = 1'b1;
        dec_ready = 1'b1;
        seen_req = 1'b0;
        drops    = 0;
        budget   = 300;
        while (pops_seen < 3 && budget > 0) begin
            tick();
            budget--;
            if (mem_req) seen_req = 1'b1;
            else if (seen_req && pops_seen < 3) drops++;
        end
        dec_ready = 1'b0;
        check("t1_pops", pops_seen, 3);
        check("t1_req_drops", drops, 0);
        check("t1_sb_empty", sb.size(), 0);

        // Test 2: decoder stalled, queue fills, one pop releases exactly one fetch.
        enter_reset();
        mem_lat = 1;
        rst_in  = 1'b1;
        budget  = 200;
        while (resp_cnt < 4 && budget > 0) begin
            tick();
            budget--;
        end
        repeat (6) tick();
        check("t2_resp_cnt", resp_cnt, 4);
        check("t2_req_cnt", req_log.size(), 4);
        check("t2_mem_req_low", {31'h0, mem_req}, 32'h0);
        check("t2_state_idle", {30'h0, dut.state_q}, 32'h0);
        check("t2_head_pc", dec_pc, 32'h0);
        exp_push(32'h0, 32'h0000_0013, 1'b0);
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        repeat (10) tick();
        check("t2_one_pop", pops_seen, 1);
        check("t2_req_cnt_after", req_log.size(), 5);
        if (req_log.size() > 4) check("t2_new_addr", req_log[4], 32'h10);
        check("t2_mem_req_low_after", {31'h0, mem_req}, 32'h0);
        check("t2_head_pc_after", dec_pc, 32'h4);

        // Test 3: redirect while waiting without a response; stale word dropped.
        enter_reset();
        mem_lat = 3;
        rst_in  = 1'b1;
        budget  = 200;
        while (!(req_log.size() == 3 && pending && lat_cnt > 0) && budget > 0) begin
            tick();
            budget--;
        end
        check("t3_setup", req_log.size(), 3);
        jump_en = 1'b1;
        jump_pc = 32'h103;
        tick();
        jump_en = 1'b0;
        check("t3_queue_empty", {31'h0, dec_valid}, 32'h0);
        check("t3_state_discard", {30'h0, dut.state_q}, 32'h2);
        check("t3_addr_held", mem_addr, 32'h8);
        check("t3_req_held", {31'h0, mem_req}, 32'h1);
        exp_push(32'h100, 32'h0001_0013, 1'b0);
        exp_push(32'h104, 32'h0001_0413, 1'b0);
        dec_ready = 1'b1;
        wait_pops(2, "t3");
        dec_ready = 1'b0;
        if (req_log.size() > 3) check("t3_next_addr", req_log[3], 32'h100);
        else check("t3_next_addr_missing", req_log.size(), 4);
        check("t3_sb_empty", sb.size(), 0);

        // Test 4: redirect coincident with the response; word dropped, refetch from IDLE.
        enter_reset();
        mem_lat = 2;
        rst_in  = 1'b1;
        budget  = 200;
        while (!(req_log.size() == 2 && pending && lat_cnt == 0) && budget > 0) begin
            tick();
            budget--;
        end
        check("t4_setup", req_log.size(), 2);
        jump_en = 1'b1;
        jump_pc = 32'h200;
        tick();
        jump_en = 1'b0;
        check("t4_mem_req_low", {31'h0, mem_req}, 32'h0);
        check("t4_state_idle", {30'h0, dut.state_q}, 32'h0);
        check("t4_queue_empty", {31'h0, dec_valid}, 32'h0);
        exp_push(32'h200, 32'h0002_0013, 1'b0);
        exp_push(32'h204, 32'h0002_0413, 1'b0);
        dec_ready = 1'b1;
        wait_pops(2, "t4");
        dec_ready = 1'b0;
        if (req_log.size() > 2) check("t4_next_addr", req_log[2], 32'h200);
        else check("t4_next_addr_missing", req_log.size(), 3);
        check("t4_sb_empty", sb.size(), 0);

        // Test 5: rdy_in low for five cycles in WAIT freezes everything.
        enter_reset();
        mem_lat = 1;
        exp_push(32'h0, 32'h0000_0013, 1'b0);
        exp_push(32'h4, 32'h0000_0413, 1'b0);
        exp_push(32'h8, 32'h0000_0813, 1'b0);
        exp_push(32'hC, 32'h0000_0C13, 1'b0);
        rst_in    = 1'b1;
        dec_ready = 1'b1;
        budget    = 200;
        while (!(req_log.size() == 2 && pending) && budget > 0) begin
            tick();
            budget--;
        end
        rdy_in = 1'b0;
        pops_before = pops_seen;
        repeat (5) tick();
        check("t5_no_pops", pops_seen, pops_before);
        check("t5_state_wait", {30'h0, dut.state_q}, 32'h1);
        check("t5_fetch_pc", dut.fetch_pc_q, 32'h4);
        check("t5_mem_addr", mem_addr, 32'h4);
        check("t5_mem_req", {31'h0, mem_req}, 32'h1);
        rdy_in = 1'b1;
        wait_pops(4, "t5");
        dec_ready = 1'b0;
        check("t5_sb_empty", sb.size(), 0);

        // Test 6: JAL at 0x20, prediction depends on the build option.
        enter_reset();
        mem_lat  = 1;
        jal_mode = 1'b1;
        jump_en  = 1'b1;
        jump_pc  = 32'h20;
        rst_in   = 1'b1;
        tick();
        jump_en  = 1'b0;
`ifdef IFETCH_JAL_PREDICT_EN
        exp_push(32'h20, 32'h0100_006F, 1'b1);
        exp_push(32'h30, 32'h0000_3013, 1'b0);
`else
        exp_push(32'h20, 32'h0100_006F, 1'b0);
        exp_push(32'h24, 32'h0000_2413, 1'b0);
`endif
        dec_ready = 1'b1;
        wait_pops(2, "t6");
        dec_ready = 1'b0;
`ifdef IFETCH_JAL_PREDICT_EN
        if (req_log.size() > 1) check("t6_next_addr", req_log[1], 32'h30);
        else check("t6_next_addr_missing", req_log.size(), 2);
`else
        if (req_log.size() > 1) check("t6_next_addr", req_log[1], 32'h24);
        else check("t6_next_addr_missing", req_log.size(), 2);
`endif
        check("t6_sb_empty", sb.size(), 0);
        jal_mode = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
